// File: rtl/misc_v_pkg.sv
// Shared types and encodings for the MISC-V hazard and forwarding controller.
package misc_v_pkg;

    localparam int RID_W = 16;

    localparam logic [1:0] FWD_MEM = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_REG = 2'b10;

    localparam logic FWD3_WB  = 1'b0;
    localparam logic FWD3_REG = 1'b1;

    typedef enum logic [1:0] {
        RUN,
        HZ_STALL,
        MEM_WAIT
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [RID_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic             mem_access;
    } shadow_t;

    // Register 0 is hard-wired when zero_reg is set, so it never produces.
    function automatic logic writes(
        input shadow_t          e,
        input logic [RID_W-1:0] r,
        input bit               zero_reg
    );
        return e.valid && e.reg_write && (e.rd == r)
            && !(zero_reg && (r == '0));
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// Per-operand forwarding source selection against the EX and MEM shadows.
module fwd_select
    import misc_v_pkg::*;
#(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             used,
    input  logic [RID_W-1:0] rs,
    input  shadow_t          ex,
    input  shadow_t          mem,
    output logic [1:0]       sel
);

    logic unused_bits;
    assign unused_bits = ^{mem.mem_read, mem.mem_access, ex.mem_access};

    // A load in EX has no result yet; the stall logic covers that case.
    always_comb begin
        sel = FWD_REG;
        if (used && writes(ex, rs, ZERO_REG) && !ex.mem_read) begin
            sel = FWD_MEM;
        end else if (used && writes(mem, rs, ZERO_REG)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection, stall/bubble/freeze control and registered forward
// selects for the MISC-V pipeline.
module hazard_fwd_ctrl
    import misc_v_pkg::*;
#(
    parameter int REG_W    = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_reg_store,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             flush,
    input  logic             mem_ready,
    output logic [1:0]       muxFwd1select,
    output logic [1:0]       muxFwd2select,
    output logic             muxFwd3select,
    output logic             stall,
    output logic             bubble,
    output logic             freeze
);

    shadow_t          ex_q, mem_q, wb_q, id_e;
    state_t           state_q;
    logic [RID_W-1:0] rs1, rs2, rd;
    logic [1:0]       sel1, sel2;
    logic             sel3;
    logic             load_hz, store_hz, hz;
    logic             unused_wb;

    assign rs1 = RID_W'(id_rs1);
    assign rs2 = RID_W'(id_rs2);
    assign rd  = RID_W'(id_rd);

    assign id_e = '{
        valid:      1'b1,
        rd:         rd,
        reg_write:  id_reg_write,
        mem_read:   id_mem_read,
        mem_access: id_mem_read | id_mem_write
    };

    fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd1 (
        .used (id_use_rs1),
        .rs   (rs1),
        .ex   (ex_q),
        .mem  (mem_q),
        .sel  (sel1)
    );

    fwd_select #(.ZERO_REG(ZERO_REG)) u_fwd2 (
        .used (id_use_rs2),
        .rs   (rs2),
        .ex   (ex_q),
        .mem  (mem_q),
        .sel  (sel2)
    );

    // Store data can only be taken from the WB bus, never from EX.
    assign sel3 = writes(mem_q, rd, ZERO_REG) ? FWD3_WB : FWD3_REG;

    assign load_hz = ex_q.mem_read
        && ((id_use_rs1 && writes(ex_q, rs1, ZERO_REG))
         || (id_use_rs2 && writes(ex_q, rs2, ZERO_REG)));
    assign store_hz = id_reg_store && writes(ex_q, rd, ZERO_REG);
    assign hz = (state_q != HZ_STALL) && (load_hz || store_hz);

    assign freeze = mem_q.valid && mem_q.mem_access && !mem_ready;
    assign stall  = !freeze && !flush && hz;
    assign bubble = !freeze && (flush || hz);

    assign unused_wb = ^wb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            muxFwd1select <= FWD_REG;
            muxFwd2select <= FWD_REG;
            muxFwd3select <= FWD3_REG;
        end else begin
            if (freeze) begin
                state_q <= MEM_WAIT;
            end else if (stall) begin
                state_q <= HZ_STALL;
            end else begin
                state_q <= RUN;
            end
            if (!freeze) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                // A squashed slot must not inherit the ID operand selects.
                if (bubble) begin
                    ex_q          <= '0;
                    muxFwd1select <= FWD_REG;
                    muxFwd2select <= FWD_REG;
                    muxFwd3select <= FWD3_REG;
                end else begin
                    ex_q          <= id_e;
                    muxFwd1select <= sel1;
                    muxFwd2select <= sel2;
                    muxFwd3select <= sel3;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed scoreboard bench for hazard_fwd_ctrl.
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_store;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush, mem_ready;
    logic [1:0]  muxFwd1select, muxFwd2select;
    logic        muxFwd3select, stall, bubble, freeze;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_W(16), .ZERO_REG(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_reg_store  (id_reg_store),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .flush         (flush),
        .mem_ready     (mem_ready),
        .muxFwd1select (muxFwd1select),
        .muxFwd2select (muxFwd2select),
        .muxFwd3select (muxFwd3select),
        .stall         (stall),
        .bubble        (bubble),
        .freeze        (freeze)
    );

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = q.pop_front();
            act = {muxFwd1select, muxFwd2select, muxFwd3select,
                   stall, bubble, freeze};
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got f1=%b f2=%b f3=%b st=%b bu=%b fr=%b, want f1=%b f2=%b f3=%b st=%b bu=%b fr=%b",
                    e.name, act[7:6], act[5:4], act[3], act[2], act[1], act[0],
                    e.val[7:6], e.val[5:4], e.val[3], e.val[2], e.val[1], e.val[0]);
            end
        end
    end

    // One pipeline cycle: drive ID inputs and queue the outputs expected now.
    task automatic step(
        input bit       rst,
        input int       rs1, rs2, rd,
        input bit       u1, u2, st, rw, mr, mw, fl, rdy,
        input bit [1:0] e1, e2,
        input bit       e3, es, eb, ef,
        input string    nm
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        id_rs1       = 16'(rs1);
        id_rs2       = 16'(rs2);
        id_rd        = 16'(rd);
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_reg_store = st;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
        flush        = fl;
        mem_ready    = rdy;
        if (!rst) begin
            e.name = nm;
            e.val  = {e1, e2, e3, es, eb, ef};
            q.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b1;
        {id_rs1, id_rs2, id_rd} = '0;
        {id_use_rs1, id_use_rs2, id_reg_store} = '0;
        {id_reg_write, id_mem_read, id_mem_write, flush} = '0;
        mem_ready = 1'b1;

        //   rst rs1 rs2 rd  u1 u2 st rw mr mw fl rdy  f1    f2    f3 st bu fr
        step(1, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "rst");
        step(1, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "rst");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "reset_state");
        // ALU r3 -> ALU rs1=r3
        step(0, 1, 0, 3,  1,0,0,1,0,0,0,1, 2'b10,2'b10,1,0,0,0, "alu_r3");
        step(0, 3, 0, 6,  1,0,0,1,0,0,0,1, 2'b10,2'b10,1,0,0,0, "alu_use_r3_id");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b00,2'b10,1,0,0,0, "alu_use_r3_ex");
        // load r5 -> add rs2=r5
        step(0, 0, 0, 5,  1,0,0,1,1,0,0,1, 2'b10,2'b10,1,0,0,0, "load_r5");
        step(0, 0, 5, 7,  0,1,0,1,0,0,0,1, 2'b10,2'b10,1,1,1,0, "load_use_stall");
        step(0, 0, 5, 7,  0,1,0,1,0,0,0,1, 2'b10,2'b10,1,0,0,0, "load_use_retry");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b01,1,0,0,0, "load_use_ex_wb");
        // ALU r4, NOP, store r4
        step(0, 0, 0, 4,  0,0,0,1,0,0,0,1, 2'b10,2'b10,1,0,0,0, "alu_r4");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "nop_gap");
        step(0, 0, 0, 4,  1,0,1,0,0,1,0,1, 2'b10,2'b10,1,0,0,0, "store_r4_gap");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,0,0,0,0, "store_gap_fwd3");
        // ALU r4 then store r4 back to back
        step(0, 0, 0, 4,  0,0,0,1,0,0,0,1, 2'b10,2'b10,1,0,0,0, "alu_r4_b2b");
        step(0, 0, 0, 4,  0,0,1,0,0,1,0,1, 2'b10,2'b10,1,1,1,0, "store_stall");
        step(0, 0, 0, 4,  0,0,1,0,0,1,0,1, 2'b10,2'b10,1,0,0,0, "store_retry");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,0,0,0,0, "store_b2b_fwd3");
        // memory wait: load r9 in MEM not ready for 3 cycles
        step(0, 0, 0, 8,  0,0,0,1,0,0,0,1, 2'b10,2'b10,1,0,0,0, "alu_r8");
        step(0, 0, 0, 9,  0,0,0,1,1,0,0,1, 2'b10,2'b10,1,0,0,0, "load_r9");
        step(0, 8, 0, 10, 1,0,0,1,0,0,0,1, 2'b10,2'b10,1,0,0,0, "use_r8");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,0, 2'b01,2'b10,1,0,0,1, "freeze_1");
        step(0, 0, 0, 0,  0,0,0,0,0,0,1,0, 2'b01,2'b10,1,0,0,1, "freeze_2_flush");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,0, 2'b01,2'b10,1,0,0,1, "freeze_3");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b01,2'b10,1,0,0,0, "mem_ready_cycle");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "after_wait");
        // load r2 then consumer squashed by flush
        step(0, 0, 0, 2,  0,0,0,1,1,0,0,1, 2'b10,2'b10,1,0,0,0, "load_r2");
        step(0, 2, 0, 11, 1,0,0,1,0,0,1,1, 2'b10,2'b10,1,0,1,0, "flush_over_hz");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "flush_ex");
        // r0 never forwards or stalls
        step(0, 0, 0, 0,  0,0,0,1,0,0,0,1, 2'b10,2'b10,1,0,0,0, "alu_r0");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "nop_r0");
        step(0, 0, 0, 0,  1,1,1,0,0,1,0,1, 2'b10,2'b10,1,0,0,0, "store_r0");
        step(0, 0, 0, 0,  0,0,0,1,1,0,0,1, 2'b10,2'b10,1,0,0,0, "load_r0");
        step(0, 0, 0, 0,  1,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "use_r0_no_stall");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "use_r0_ex");
        // reset in the middle of a memory wait
        step(0, 0, 0, 13, 0,0,0,1,0,0,0,1, 2'b10,2'b10,1,0,0,0, "alu_r13");
        step(0, 13, 0, 12,1,0,0,1,1,0,0,1, 2'b10,2'b10,1,0,0,0, "load_r12");
        step(0, 13, 0, 0, 1,0,0,0,0,0,0,1, 2'b00,2'b10,1,0,0,0, "use_r13");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,0, 2'b01,2'b10,1,0,0,1, "wait_before_rst");
        step(1, 0, 0, 0,  0,0,0,0,0,0,0,0, 2'b10,2'b10,1,0,0,0, "rst");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,0, 2'b10,2'b10,1,0,0,0, "rst_mid_wait");
        step(0, 0, 0, 0,  0,0,0,0,0,0,0,1, 2'b10,2'b10,1,0,0,0, "post_rst");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 16-bit MISC-V core. Shadows destination and control information of the EX, MEM and WB stages. Produces the registered forwarding selects consumed by the Execute stage operand muxes, and the load-use / store-data stall and bubble controls for IF/ID and ID/EX. Freezes the whole pipeline while data memory is not ready.

## Interface
- REG_W, 16, width of register identifier fields (matches Rs1/Rs2/Rd buses)
- ZERO_REG, 1, when 1 a destination of 0 never forwards and never stalls
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2, id_rd  in  REG_W  source and destination identifiers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction reads operand 1 / operand 2
- id_reg_store  in  1  ID instruction is a store; its 3rd arg (store data) is register id_rd
- id_reg_write, id_mem_read, id_mem_write  in  1  ID instruction control bits
- flush  in  1  squash the instruction in ID (taken branch/jump)
- mem_ready  in  1  data memory completes the MEM-stage access this cycle
- muxFwd1select, muxFwd2select  out  2  EX operand select: 00 MEM ALU result, 01 WB data, 10 register-file value
- muxFwd3select  out  1  EX store-data select: 0 WB data, 1 register-file value
- stall  out  1  hold PC and IF/ID this cycle
- bubble  out  1  load a NOP into ID/EX this cycle
- freeze  out  1  hold every pipeline register this cycle

## Operation
- Shadow entries EX, MEM, WB: {valid, rd, reg_write, mem_read, mem_access}.
- An entry "writes r" when valid & reg_write & rd==r & !(ZERO_REG & r==0).
- Advance on each non-frozen cycle: WB<=MEM, MEM<=EX, EX<=(bubble|flush) ? invalid : ID fields.
- Forward selects are computed from ID inputs against the current EX/MEM shadows and registered on advance, so they are valid while that instruction is in EX.
  - Operand n used and EX writes rs_n with !mem_read: FWD_MEM (00).
  - Else MEM writes rs_n: FWD_WB (01).
  - Else FWD_REG (10).
  - Unused operand: FWD_REG.
- The store-data path has only a WB source.
  - MEM writes id_rd: muxFwd3select=0.
  - Otherwise: 1.
- Hazard conditions, evaluated combinationally against the EX shadow:
  - Load-use: EX is mem_read and writes a used id_rs1 or id_rs2.
  - Store-data: id_reg_store and EX writes id_rd, whether EX is a load or an ALU op.
  - Either condition gives stall=1 and bubble=1 for exactly one cycle. On the next cycle the producer is in MEM and the operand resolves to 01 or to a MEM forward.
- FSM states:
  - RUN: normal operation.
  - HZ_STALL: single cycle; the ID instruction is re-evaluated. Always returns to RUN unless freeze applies.
  - MEM_WAIT: entered when the MEM shadow is valid, has mem_access, and mem_ready=0. Holds with freeze=1 while mem_ready=0. Exits to RUN on the cycle mem_ready=1; that cycle is not frozen.
- Priority: freeze > flush > hazard stall.
  - While frozen, stall/bubble=0 and all state holds.
  - With flush, no stall is raised and EX receives a bubble.
- Reset:
  - All shadows invalid; state RUN.
  - muxFwd1select=muxFwd2select=10, muxFwd3select=1.
  - stall=bubble=freeze=0.
  - Reset mid-stall or mid-MEM_WAIT abandons it immediately.

## Timing
- Forward selects: registered, one-cycle latency from ID evaluation; they change only on advance.
- stall, bubble, freeze: combinational (Mealy) from inputs and state, valid in the same cycle.
- A load followed immediately by a dependent instruction costs exactly 1 bubble. A dependent instruction two slots later costs 0 bubbles and gets select 01.
- A memory access with N not-ready cycles adds exactly N frozen cycles. Forward registers and shadows are unchanged across them.
- Back-to-back hazards are evaluated fresh each RUN cycle. No hazard is remembered across a flush.

## Structure
- Shared package misc_v_pkg holds:
  - FWD_MEM=2'b00, FWD_WB=2'b01, FWD_REG=2'b10
  - FWD3_WB=1'b0, FWD3_REG=1'b1
  - FSM state encoding {RUN, HZ_STALL, MEM_WAIT}
  - the shadow-entry struct type
- One sub-module, fwd_select: combinational per-operand priority compare against the EX/MEM shadows. Instantiated for operand 1 and operand 2. Store data uses inline logic.

## Test plan
- ALU r3 then ALU reading rs1=r3: the consumer's EX cycle has muxFwd1select=00, with no stall or bubble.
- Load r5 then ADD rs2=r5: one cycle with stall=1, bubble=1. The consumer then enters EX with muxFwd2select=01, and the load-use condition never repeats.
- ALU r4, NOP, store with id_rd=r4: muxFwd3select=0 in the store's EX cycle, with no stall. Store immediately after ALU r4: one stall, then 0.
- Load in MEM with mem_ready low for 3 cycles: freeze=1 for exactly 3 cycles and the forward selects are held. Advance occurs on the mem_ready=1 cycle.
- Load r2 followed by a consumer of r2, with flush asserted in the consumer's ID cycle: stall=0, bubble=1, and the next EX sees 10/10/1.
- Dependency on r0 with ZERO_REG=1: selects stay 10 and there is no stall. Reset asserted during MEM_WAIT: all outputs return to reset values the following cycle.
